// File: rtl/fir_mode_sequencer.sv
// fir_mode_sequencer
// Switches the ADC path between raw bypass and the FIR low-pass path without
// glitches. While the FIR delay line fills (entering filter mode) or is
// flushed with midscale (leaving it), the displayed sample is frozen so no
// transient reaches the trigger/display. A minimum dwell time is enforced in
// each steady mode before another switch is honoured.
//
// Ports:
//   ad_clk      in   sole clock (ADC sample clock)
//   rst         in   synchronous reset, active-high
//   fir_req     in   requested mode level, 1 = filter, 0 = bypass
//   ad_data     in   raw ADC sample (unsigned, DATA_W)
//   filt_data   in   gain-compensated FIR output sample (unsigned, DATA_W)
//   fir_en      out  FIR enable, high in FILL, FILTER and DRAIN
//   fir_xin     out  FIR input sample, registered
//   ad_data_out out  sample forwarded to trigger/display, registered
//   busy        out  high in FILL or DRAIN
//   fir_active  out  high in FILTER
module fir_mode_sequencer #(
  parameter int DATA_W    = 8,
  parameter int FILL_CYC  = 40,
  parameter int DRAIN_CYC = 40,
  parameter int DWELL_CYC = 16,
  parameter int MIDSCALE  = 128
) (
  input  logic              ad_clk,
  input  logic              rst,
  input  logic              fir_req,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [DATA_W-1:0] filt_data,
  output logic              fir_en,
  output logic [DATA_W-1:0] fir_xin,
  output logic [DATA_W-1:0] ad_data_out,
  output logic              busy,
  output logic              fir_active
);

  // One counter width covers fill, drain and dwell so none of them can wrap.
  localparam int MAX_FD  = (FILL_CYC > DRAIN_CYC) ? FILL_CYC : DRAIN_CYC;
  localparam int MAX_CYC = (MAX_FD > DWELL_CYC) ? MAX_FD : DWELL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  FILL_LAST  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYC);
  localparam logic [DATA_W-1:0] MID_VAL    = DATA_W'(MIDSCALE);

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    FILL   = 2'd1,
    FILTER = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  dwell;
  logic [DATA_W-1:0] hold_reg;

  // Decrement that sticks at zero; zero means the dwell has expired.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      state       <= BYPASS;
      cnt         <= '0;
      dwell       <= '0;
      hold_reg    <= '0;
      ad_data_out <= '0;
      fir_xin     <= '0;
    end else begin
      // Default dwell behaviour; a steady-state entry below overrides it.
      dwell <= sat_dec(dwell);
      case (state)
        BYPASS: begin
          ad_data_out <= ad_data;
          fir_xin     <= ad_data;
          if (fir_req && (dwell == '0)) begin
            state    <= FILL;
            cnt      <= '0;
            // Freeze on the very sample being shown this cycle.
            hold_reg <= ad_data;
          end
        end
        FILL: begin
          ad_data_out <= hold_reg;
          fir_xin     <= ad_data;
          cnt         <= cnt + CNT_W'(1);
          if (cnt == FILL_LAST) begin
            state <= FILTER;
            dwell <= DWELL_LOAD;
          end
        end
        FILTER: begin
          ad_data_out <= filt_data;
          fir_xin     <= ad_data;
          if (!fir_req && (dwell == '0)) begin
            state    <= DRAIN;
            cnt      <= '0;
            hold_reg <= filt_data;
          end
        end
        DRAIN: begin
          ad_data_out <= hold_reg;
          // Flush the delay line with midscale so the next fill starts clean.
          fir_xin     <= MID_VAL;
          cnt         <= cnt + CNT_W'(1);
          if (cnt == DRAIN_LAST) begin
            state <= BYPASS;
            dwell <= DWELL_LOAD;
          end
        end
        default: state <= BYPASS;
      endcase
    end
  end

  // Status decoded straight from the state register, no added latency.
  assign fir_en     = (state != BYPASS);
  assign busy       = (state == FILL) || (state == DRAIN);
  assign fir_active = (state == FILTER);

endmodule

// File: tb/tb_fir_mode_sequencer.sv
// Testbench for fir_mode_sequencer. Two instances share the same stimulus:
// u0 uses FILL=4, DRAIN=3, DWELL=2; u1 uses the boundary case FILL=1,
// DRAIN=1, DWELL=0. A driver issues inputs and pushes the expected outputs
// from a cycle-level reference model; a monitor pops and compares.
module tb_fir_mode_sequencer;

  localparam int DW = 8;

  logic          ad_clk = 1'b0;
  logic          rst;
  logic          fir_req;
  logic [DW-1:0] ad_data;
  logic [DW-1:0] filt_data;
  logic [1:0]    en;
  logic [1:0]    bsy;
  logic [1:0]    act;
  logic [DW-1:0] dout [2];
  logic [DW-1:0] xin  [2];

  always #5 ad_clk = ~ad_clk;

  fir_mode_sequencer #(.DATA_W(DW), .FILL_CYC(4), .DRAIN_CYC(3),
                       .DWELL_CYC(2), .MIDSCALE(128)) u0 (
    .ad_clk(ad_clk), .rst(rst), .fir_req(fir_req), .ad_data(ad_data),
    .filt_data(filt_data), .fir_en(en[0]), .fir_xin(xin[0]),
    .ad_data_out(dout[0]), .busy(bsy[0]), .fir_active(act[0]));

  fir_mode_sequencer #(.DATA_W(DW), .FILL_CYC(1), .DRAIN_CYC(1),
                       .DWELL_CYC(0), .MIDSCALE(128)) u1 (
    .ad_clk(ad_clk), .rst(rst), .fir_req(fir_req), .ad_data(ad_data),
    .filt_data(filt_data), .fir_en(en[1]), .fir_xin(xin[1]),
    .ad_data_out(dout[1]), .busy(bsy[1]), .fir_active(act[1]));

  typedef struct packed {
    logic [DW-1:0] out;
    logic [DW-1:0] xin;
    logic          en;
    logic          busy;
    logic          act;
  } exp_t;

  typedef struct packed {
    exp_t i0;
    exp_t i1;
  } exp_pair_t;

  exp_pair_t q[$];
  int errors = 0;
  int checks = 0;

  function automatic int fill_n(int k);  return (k == 0) ? 4 : 1; endfunction
  function automatic int drain_n(int k); return (k == 0) ? 3 : 1; endfunction
  function automatic int dwell_n(int k); return (k == 0) ? 2 : 0; endfunction

  // Reference model: mode 0 bypass, 1 fill, 2 filter, 3 drain.
  // m_age = cycles already spent in the current mode; a steady mode may be
  // left once it has been occupied for at least DWELL cycles before the edge.
  int            m_mode [2];
  int            m_age  [2];
  logic [DW-1:0] m_hold [2];
  logic [DW-1:0] m_out  [2];
  logic [DW-1:0] m_xin  [2];

  function automatic void model_step(int k, logic r, logic req,
                                     logic [DW-1:0] a, logic [DW-1:0] f);
    if (r) begin
      m_mode[k] = 0;
      m_age[k]  = dwell_n(k);
      m_hold[k] = '0;
      m_out[k]  = '0;
      m_xin[k]  = '0;
      return;
    end
    case (m_mode[k])
      0: begin
        m_out[k] = a;
        m_xin[k] = a;
        if (req && m_age[k] >= dwell_n(k)) begin
          m_hold[k] = a; m_mode[k] = 1; m_age[k] = 0;
        end else m_age[k]++;
      end
      1: begin
        m_out[k] = m_hold[k];
        m_xin[k] = a;
        if (m_age[k] == fill_n(k) - 1) begin
          m_mode[k] = 2; m_age[k] = 0;
        end else m_age[k]++;
      end
      2: begin
        m_out[k] = f;
        m_xin[k] = a;
        if (!req && m_age[k] >= dwell_n(k)) begin
          m_hold[k] = f; m_mode[k] = 3; m_age[k] = 0;
        end else m_age[k]++;
      end
      default: begin
        m_out[k] = m_hold[k];
        m_xin[k] = 8'd128;
        if (m_age[k] == drain_n(k) - 1) begin
          m_mode[k] = 0; m_age[k] = 0;
        end else m_age[k]++;
      end
    endcase
  endfunction

  function automatic exp_t expect_of(int k);
    exp_t e;
    e.out  = m_out[k];
    e.xin  = m_xin[k];
    e.en   = (m_mode[k] != 0);
    e.busy = (m_mode[k] == 1) || (m_mode[k] == 3);
    e.act  = (m_mode[k] == 2);
    return e;
  endfunction

  // Apply one cycle of inputs; expected post-edge outputs go to the queue.
  task automatic drive(input logic r, input logic req,
                       input logic [DW-1:0] a, input logic [DW-1:0] f);
    exp_pair_t e;
    rst       = r;
    fir_req   = req;
    ad_data   = a;
    filt_data = f;
    model_step(0, r, req, a, f);
    model_step(1, r, req, a, f);
    e.i0 = expect_of(0);
    e.i1 = expect_of(1);
    q.push_back(e);
    @(negedge ad_clk);
  endtask

  logic [DW-1:0] ramp;
  task automatic step(input logic r, input logic req, input logic [DW-1:0] f);
    drive(r, req, ramp, f);
    ramp = ramp + 8'd1;
  endtask

  task automatic chk(input string name, input int k,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s u%0d: got %0h expected %0h at %0t",
               name, k, got, want, $time);
    end
  endtask

  // Monitor: every clock presents a new output set, compared #1 after edge.
  initial begin
    exp_pair_t e;
    exp_t      x;
    forever begin
      @(posedge ad_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          x = (k == 0) ? e.i0 : e.i1;
          chk("ad_data_out", k, 32'(dout[k]), 32'(x.out));
          chk("fir_xin",     k, 32'(xin[k]),  32'(x.xin));
          chk("fir_en",      k, 32'(en[k]),   32'(x.en));
          chk("busy",        k, 32'(bsy[k]),  32'(x.busy));
          chk("fir_active",  k, 32'(act[k]),  32'(x.act));
        end
      end
    end
  end

  initial begin
    logic rq;
    ramp = '0;
    // Power-up reset, a short ramp, then reset held 3 cycles mid-ramp.
    repeat (2) step(1'b1, 1'b0, 8'd0);
    repeat (5) step(1'b0, 1'b0, 8'd0);
    repeat (3) step(1'b1, 1'b0, 8'd0);
    // ramp is now 10: request filter mode and stay there.
    repeat (10) step(1'b0, 1'b1, 8'($urandom));
    // Leave filter with filt_data = 77 held through the drain.
    repeat (8) step(1'b0, 1'b0, 8'd77);
    repeat (4) step(1'b0, 1'b0, 8'($urandom));
    // One-cycle request starts FILL; a later pulse inside FILL is ignored.
    step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    repeat (8) step(1'b0, 1'b0, 8'($urandom));
    // Request toggling every cycle right after re-entering bypass.
    for (int i = 0; i < 12; i++) step(1'b0, logic'(i[0]), 8'($urandom));
    // Reach FILTER, then DRAIN, and reset on the second DRAIN cycle.
    for (int i = 0; i < 40 && m_mode[0] != 2; i++) step(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 40 && m_mode[0] != 3; i++) step(1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 8'($urandom));
    repeat (6) step(1'b0, 1'b1, 8'($urandom));
    // Randomized traffic: slowly changing request level, rare resets.
    rq = 1'b0;
    repeat (1500) begin
      if ($urandom_range(7) == 0) rq = ~rq;
      drive(($urandom_range(199) == 0), rq, 8'($urandom), 8'($urandom));
    end
    repeat (2) @(negedge ad_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
